// File: rtl/cnn_window_gen_if.sv
// Pixel-in / window-out bus between the DMA pixel stream, cnn_window_gen and cnn_core.
// The source of pixels is the master; the window generator is the slave.
interface cnn_window_gen_if #(
  parameter int CI      = 1,
  parameter int KX      = 3,
  parameter int KY      = 3,
  parameter int I_FM_BW = 8
);
  localparam int PIX_W = CI * I_FM_BW;
  localparam int WIN_W = PIX_W * KX * KY;

  logic             i_in_valid;
  logic [PIX_W-1:0] i_in_pixel;
  logic             o_ot_valid;
  logic [WIN_W-1:0] o_ot_window;
  logic             o_frame_done;

  modport master (
    output i_in_valid,
    output i_in_pixel,
    input  o_ot_valid,
    input  o_ot_window,
    input  o_frame_done
  );

  modport slave (
    input  i_in_valid,
    input  i_in_pixel,
    output o_ot_valid,
    output o_ot_window,
    output o_frame_done
  );
endinterface

// File: rtl/cnn_window_gen.sv
// Stride-1, no-padding KXxKY sliding-window generator over a raster pixel stream.
// Emits one packed window per completing pixel, in the cnn_core i_in_fmap layout.
module cnn_window_gen #(
  parameter int CI      = 1,
  parameter int KX      = 3,
  parameter int KY      = 3,
  parameter int I_FM_BW = 8,
  parameter int IMG_W   = 28,
  parameter int IMG_H   = 28
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            i_soft_reset,
  cnn_window_gen_if.slave bus,
  output logic            o_busy
);

  localparam int PIX_W  = CI * I_FM_BW;
  localparam int WIN_W  = PIX_W * KX * KY;
  localparam int LB_LEN = (KY - 1) * IMG_W;
  localparam int COL_W  = $clog2(IMG_W);
  localparam int ROW_W  = $clog2(IMG_H);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_WIN  = COL_W'(KX - 1);
  localparam logic [ROW_W-1:0] ROW_WIN  = ROW_W'(KY - 1);

  typedef logic [PIX_W-1:0] pix_t;

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;

  // lb_q[j] holds the pixel accepted j+1 pixels ago, so the pixel k lines
  // above the incoming one sits at lb_q[k*IMG_W-1].
  pix_t lb_q  [LB_LEN];
  pix_t lb_d  [LB_LEN];
  pix_t win_q [KY][KX];
  pix_t win_d [KY][KX];

  logic             accept;
  logic             col_wrap;
  logic             row_wrap;
  logic             win_complete;
  logic [WIN_W-1:0] window_packed;

  // ---------------------------------------------------------------------------
  // Raster counters and output strobes
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first, so no path can leave
  // a signal unassigned and infer a latch.
  always_comb begin
    accept       = bus.i_in_valid && !i_soft_reset;
    col_wrap     = (col_q == COL_LAST);
    row_wrap     = (row_q == ROW_LAST);
    win_complete = (row_q >= ROW_WIN) && (col_q >= COL_WIN);

    col_d   = col_q;
    row_d   = row_q;
    valid_d = 1'b0;
    done_d  = 1'b0;

    if (i_soft_reset) begin
      col_d = '0;
      row_d = '0;
    end else if (bus.i_in_valid) begin
      valid_d = win_complete;
      done_d  = col_wrap && row_wrap;
      if (col_wrap) begin
        col_d = '0;
        row_d = row_wrap ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Line buffer and window shift
  // ---------------------------------------------------------------------------
  always_comb begin
    lb_d  = lb_q;
    win_d = win_q;

    if (accept) begin
      lb_d[0] = bus.i_in_pixel;
      for (int i = 1; i < LB_LEN; i++) begin
        lb_d[i] = lb_q[i-1];
      end

      for (int ky = 0; ky < KY; ky++) begin
        for (int kx = 0; kx < KX - 1; kx++) begin
          win_d[ky][kx] = win_q[ky][kx+1];
        end
      end

      // New right column: taps are read before this pixel enters the buffer.
      for (int ky = 0; ky < KY - 1; ky++) begin
        win_d[ky][KX-1] = lb_q[(KY - 1 - ky) * IMG_W - 1];
      end
      win_d[KY-1][KX-1] = bus.i_in_pixel;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // NOTE: the pixel storage is reset on purpose: an async reset must leave no
  // previous image data visible, which rules out mapping it to an unreset RAM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LB_LEN; i++) begin
        lb_q[i] <= '0;
      end
      for (int ky = 0; ky < KY; ky++) begin
        for (int kx = 0; kx < KX; kx++) begin
          win_q[ky][kx] <= '0;
        end
      end
    end else begin
      lb_q  <= lb_d;
      win_q <= win_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output packing: sample (c, ky, kx) at ((c*KY+ky)*KX+kx)*I_FM_BW
  // ---------------------------------------------------------------------------
  always_comb begin
    window_packed = '0;
    for (int c = 0; c < CI; c++) begin
      for (int ky = 0; ky < KY; ky++) begin
        for (int kx = 0; kx < KX; kx++) begin
          window_packed[((c * KY + ky) * KX + kx) * I_FM_BW +: I_FM_BW] =
            win_q[ky][kx][c * I_FM_BW +: I_FM_BW];
        end
      end
    end
  end

  assign bus.o_ot_valid   = valid_q;
  assign bus.o_ot_window  = window_packed;
  assign bus.o_frame_done = done_q;
  assign o_busy           = (col_q != '0) || (row_q != '0);

endmodule

// File: tb/tb_cnn_window_gen.sv
// Scoreboard bench for cnn_window_gen: a CI=1 and a CI=2 instance on 4x4 frames,
// expected windows computed from an image model and checked as the DUTs emit them.
module tb_cnn_window_gen;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int KX = 3;
  localparam int KY = 3;
  localparam int BW = 8;
  localparam int WIN1 = KX * KY * BW;
  localparam int WIN2 = 2 * WIN1;

  localparam logic [WIN1-1:0] FIRST_W = {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0};
  localparam logic [WIN1-1:0] LAST_W  = {8'd15, 8'd14, 8'd13, 8'd11, 8'd10, 8'd9, 8'd7, 8'd6, 8'd5};
  localparam logic [WIN1-1:0] F2_W    = {8'd110, 8'd109, 8'd108, 8'd106, 8'd105, 8'd104, 8'd102, 8'd101, 8'd100};
  localparam logic [WIN1-1:0] CH1_W   = {8'd74, 8'd73, 8'd72, 8'd70, 8'd69, 8'd68, 8'd66, 8'd65, 8'd64};

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic soft_rst = 1'b0;
  logic busy1, busy2;

  always #5 clk = ~clk;

  cnn_window_gen_if #(.CI(1), .KX(KX), .KY(KY), .I_FM_BW(BW)) bus1 ();
  cnn_window_gen_if #(.CI(2), .KX(KX), .KY(KY), .I_FM_BW(BW)) bus2 ();

  cnn_window_gen #(.CI(1), .KX(KX), .KY(KY), .I_FM_BW(BW), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .reset_n(reset_n), .i_soft_reset(soft_rst), .bus(bus1.slave), .o_busy(busy1)
  );

  cnn_window_gen #(.CI(2), .KX(KX), .KY(KY), .I_FM_BW(BW), .IMG_W(W), .IMG_H(H)) dut2 (
    .clk(clk), .reset_n(reset_n), .i_soft_reset(soft_rst), .bus(bus2.slave), .o_busy(busy2)
  );

  typedef struct {
    logic [WIN1-1:0] w1;
    logic [WIN2-1:0] w2;
    logic            done;
    int              cyc;
  } win_t;

  win_t exp_q[$];
  win_t seen_q[$];
  win_t mon_e;
  win_t mon_s;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  logic [7:0] img [H][W];
  int m_row = 0;
  int m_col = 0;
  bit bubble_mode = 1'b0;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, want);
  endtask

  task automatic drive(input logic v, input logic [7:0] pix, input logic sr);
    @(negedge clk);
    bus1.i_in_valid = v;
    bus1.i_in_pixel = pix;
    bus2.i_in_valid = v;
    bus2.i_in_pixel = {pix + 8'd64, pix};
    soft_rst        = sr;
  endtask

  task automatic model_clear();
    m_row = 0;
    m_col = 0;
  endtask

  // Image model: store the pixel at its raster position; if it completes a
  // window, build the expected packed window straight from the stored image.
  task automatic send(input logic [7:0] pix);
    win_t e;
    logic [7:0] s;
    drive(1'b1, pix, 1'b0);
    img[m_row][m_col] = pix;
    if (m_row >= KY - 1 && m_col >= KX - 1) begin
      e.w1 = '0;
      e.w2 = '0;
      for (int ky = 0; ky < KY; ky++) begin
        for (int kx = 0; kx < KX; kx++) begin
          s = img[m_row - (KY - 1) + ky][m_col - (KX - 1) + kx];
          e.w1[(ky * KX + kx) * BW +: BW]        = s;
          e.w2[(ky * KX + kx) * BW +: BW]        = s;
          e.w2[((KY + ky) * KX + kx) * BW +: BW] = s + 8'd64;
        end
      end
      e.done = (m_row == H - 1) && (m_col == W - 1);
      e.cyc  = cyc + 1;
      exp_q.push_back(e);
    end
    if (m_col == W - 1) begin
      m_col = 0;
      m_row = (m_row == H - 1) ? 0 : m_row + 1;
    end else begin
      m_col++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'd0, 1'b0);
  endtask

  task automatic run_frame(input int base, input int gap);
    for (int i = 0; i < W * H; i++) begin
      send(8'(base + i));
      idle(gap);
    end
  endtask

  task automatic end_scenario(input string name, input int n_win);
    idle(4);
    check({name, "_window_count"}, seen_q.size(), n_win);
    check({name, "_pending"}, exp_q.size(), 0);
  endtask

  task automatic check_basic(input string name);
    if (seen_q.size() >= 4) begin
      check({name, "_first_window"}, seen_q[0].w1, FIRST_W);
      check({name, "_first_done"}, seen_q[0].done, 1'b0);
      check({name, "_last_window"}, seen_q[3].w1, LAST_W);
      check({name, "_last_done"}, seen_q[3].done, 1'b1);
    end
  endtask

  // Monitor: sample on the falling edge, pop the oldest expected window per valid.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_valid = 1'b0;
    end else begin
      if (bus1.o_ot_valid || bus2.o_ot_valid) begin
        mon_s.w1   = bus1.o_ot_window;
        mon_s.w2   = bus2.o_ot_window;
        mon_s.done = bus1.o_frame_done;
        mon_s.cyc  = cyc;
        seen_q.push_back(mon_s);
        if (exp_q.size() == 0) begin
          check("unexpected_valid", {bus1.o_ot_valid, bus2.o_ot_valid}, 2'b00);
        end else begin
          mon_e = exp_q.pop_front();
          check("valid_pair", bus2.o_ot_valid, bus1.o_ot_valid);
          check("window", bus1.o_ot_window, mon_e.w1);
          check("window_ci2", bus2.o_ot_window, mon_e.w2);
          check("frame_done", bus1.o_frame_done, mon_e.done);
          check("frame_done_ci2", bus2.o_frame_done, mon_e.done);
          check("latency", cyc, mon_e.cyc);
          if (bubble_mode) check("valid_back_to_back", prev_valid, 1'b0);
        end
      end else begin
        check("idle_frame_done", {bus1.o_frame_done, bus2.o_frame_done}, 2'b00);
      end
      prev_valid = bus1.o_ot_valid;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, expected completion earlier");
    $fatal(1);
  end

  initial begin
    bus1.i_in_valid = 1'b0;
    bus1.i_in_pixel = '0;
    bus2.i_in_valid = 1'b0;
    bus2.i_in_pixel = '0;

    repeat (3) @(negedge clk);
    check("rst_valid", bus1.o_ot_valid, 1'b0);
    check("rst_window", bus1.o_ot_window, '0);
    check("rst_window_ci2", bus2.o_ot_window, '0);
    check("rst_done", bus1.o_frame_done, 1'b0);
    check("rst_busy", busy1, 1'b0);
    reset_n = 1'b1;

    // Basic frame, back-to-back pixels
    seen_q.delete();
    run_frame(0, 0);
    end_scenario("basic", 4);
    check_basic("basic");

    // Three bubble cycles between every pixel
    seen_q.delete();
    bubble_mode = 1'b1;
    run_frame(0, 3);
    end_scenario("bubbles", 4);
    check_basic("bubbles");
    bubble_mode = 1'b0;

    // Two frames with no gap between them
    seen_q.delete();
    run_frame(0, 0);
    run_frame(100, 0);
    end_scenario("b2b", 8);
    if (seen_q.size() >= 8) begin
      check("b2b_f1_last_done", seen_q[3].done, 1'b1);
      check("b2b_f2_first_window", seen_q[4].w1, F2_W);
      check("b2b_f2_last_done", seen_q[7].done, 1'b1);
    end

    // Soft reset coincident with pixel 7, which must be dropped
    seen_q.delete();
    for (int i = 0; i < 7; i++) send(8'(i));
    drive(1'b0, 8'd0, 1'b0);
    check("sr_busy_before", busy1, 1'b1);
    drive(1'b1, 8'd7, 1'b1);
    model_clear();
    drive(1'b0, 8'd0, 1'b0);
    check("sr_busy_after", busy1, 1'b0);
    check("sr_busy_after_ci2", busy2, 1'b0);
    run_frame(0, 0);
    end_scenario("soft_reset", 4);
    check_basic("soft_reset");

    // Async reset mid-cycle after pixel 12
    seen_q.delete();
    for (int i = 0; i <= 12; i++) send(8'(i));
    drive(1'b0, 8'd0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_valid", bus1.o_ot_valid, 1'b0);
    check("arst_window", bus1.o_ot_window, '0);
    check("arst_window_ci2", bus2.o_ot_window, '0);
    check("arst_done", bus1.o_frame_done, 1'b0);
    check("arst_busy", busy1, 1'b0);
    exp_q.delete();
    seen_q.delete();
    model_clear();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    run_frame(0, 0);
    end_scenario("async_reset", 4);
    check_basic("async_reset");

    // Two-channel packing, taken from the last frame
    if (seen_q.size() >= 1) begin
      check("ci2_ch0", seen_q[0].w2[WIN1-1:0], FIRST_W);
      check("ci2_ch1", seen_q[0].w2[WIN2-1:WIN1], CH1_W);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cnn_window_gen.md
# cnn_window_gen

Sliding-window generator directly upstream of `cnn_core`. It takes a raster-order pixel stream from the AXI/DMA side, CI channels per pixel, and buffers KY-1 image lines. It emits one KX×KY×CI window per cycle, stride 1 and no padding, already packed in the `i_in_fmap` format that `cnn_core` consumes. There is no backpressure; `cnn_core` accepts every valid window.

## Interface
- `CI`, 1: input channels per pixel.
- `KX`, 3: kernel width (≥2).
- `KY`, 3: kernel height (≥2).
- `I_FM_BW`, 8: bits per channel sample.
- `IMG_W`, 28: frame width in pixels (≥KX).
- `IMG_H`, 28: frame height in pixels (≥KY).

- `clk`  in  1  single clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `i_soft_reset`  in  1  synchronous frame restart.
- `i_in_valid`  in  1  pixel present this cycle.
- `i_in_pixel`  in  CI*I_FM_BW  pixel; channel c at bits `[c*I_FM_BW +: I_FM_BW]`.
- `o_ot_valid`  out  1  window valid, 1-cycle pulse per window.
- `o_ot_window`  out  CI*KX*KY*I_FM_BW  packed window, drives `cnn_core.i_in_fmap`.
- `o_frame_done`  out  1  pulse coincident with the last window of a frame.
- `o_busy`  out  1  frame in progress (col or row counter ≠ 0).

## Operation
- Column counter `col` runs 0..IMG_W-1; row counter `row` runs 0..IMG_H-1. Both advance only on an accepted pixel (`i_in_valid`=1).
- `col` wraps to 0 at IMG_W-1 and increments `row`. `row` wraps to 0 at IMG_H-1, which begins the next frame; no idle gap is needed.
- Line buffers hold KY-1 rows of IMG_W pixels each, as shift registers or single-port RAM. On each accepted pixel they shift by one.
- Window register is a KY×KX array of pixels. On each accepted pixel every row shifts left by one column, and the new right column is loaded:
  - row ky=KY-1 takes the incoming pixel;
  - row ky<KY-1 takes the line-buffer tap holding the pixel (KY-1-ky) lines above.
- Window is complete when `row ≥ KY-1` and `col ≥ KX-1`, evaluated on the pre-increment counters of the accepted pixel.
- Packing: sample (c, ky, kx) sits at offset `((c*KY+ky)*KX+kx)*I_FM_BW`. ky=0 is the top (oldest) row; kx=0 is the leftmost (oldest) column.
- Windows per frame = (IMG_H-KY+1)*(IMG_W-KX+1).
- Partial windows that straddle a row boundary are never flagged valid. Stale buffer contents are harmless because the counters gate the output.
- `i_soft_reset`=1 clears `col`, `row`, `o_ot_valid` and `o_frame_done` next cycle.
  - Buffer and window data are not cleared.
  - Soft reset wins over a simultaneous `i_in_valid`; that pixel is dropped.
- Async reset clears all state, including buffers, window and outputs, at any time, including mid-frame.
- Arithmetic is limited to counters; no data arithmetic. Counter widths are `$clog2(IMG_W)` and `$clog2(IMG_H)`.

## Timing
- Reset values: `o_ot_valid`=0, `o_ot_window`=0, `o_frame_done`=0, `o_busy`=0.
- Latency: the window completed by pixel P appears with `o_ot_valid`=1 exactly 1 cycle after P's accept edge.
- `o_ot_window` holds its value when `o_ot_valid`=0. It changes only on accepted pixels.
- Bubbles (`i_in_valid`=0) freeze all state; gaps of any length are allowed.
- `o_frame_done` is 1 on the same cycle as the `o_ot_valid` for pixel (IMG_H-1, IMG_W-1), and 0 otherwise.
- `o_busy` is combinational from the counters. It is 0 after the last pixel of a frame wraps the counters.
- Throughput: 1 pixel/cycle sustained. Peak output is 1 window/cycle.

## Test plan
- **Basic 4×4 frame** (IMG_W=IMG_H=4, KX=KY=3, CI=1, I_FM_BW=8), pixels 0..15 back-to-back:
  - 4 windows, one cycle after pixels 10, 11, 14, 15.
  - First window packs 0,1,2,4,5,6,8,9,10 (kx fastest).
  - Last window packs 5,6,7,9,10,11,13,14,15, with `o_frame_done`=1.
- **Bubbles:** same frame with `i_in_valid` low for 3 cycles between every pixel:
  - identical 4 windows, each 1 cycle after pixels 10, 11, 14, 15;
  - `o_ot_valid` never high for 2 consecutive cycles.
- **Back-to-back frames:** two frames with frame 2 pixels = 100..115:
  - no valid window during frame-2 pixels 0..9;
  - frame-2 first window = 100,101,102,104,105,106,108,109,110.
- **Soft reset:** pulse `i_soft_reset` after pixel 6, same cycle as a valid pixel 7 (dropped), then restart the frame with 0..15:
  - exactly 4 windows, matching the basic scenario;
  - `o_busy`=0 the cycle after the soft reset.
- **Async reset:** assert `reset_n`=0 mid-cycle after pixel 12:
  - all outputs 0 immediately;
  - after release, a full frame 0..15 gives the basic-scenario result.
- **CI=2:** channel 1 = pixel+64, 4×4 frame:
  - first window channel-1 samples at offsets 9..17 = 64,65,66,68,69,70,72,73,74.
